// File: rtl/clock_divider_prog.sv
// Runtime-programmable integer clock divider with glitch-free divisor updates.
// Define CLKDIV_HALF_CYCLE_EN for an exact 50 % duty cycle on odd divisors.
module clock_divider_prog #(
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 4
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] div_val,
    input  logic             div_load,
    output logic             clk_out,
    output logic             tick,
    output logic             upd_pending
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO = CNT_W'(2);
    localparam logic [CNT_W-1:0] DEF = CNT_W'(DEFAULT_DIV);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] n_act;
    logic [CNT_W-1:0] p_div;
    logic             pend;
    logic             clk_q;
    logic             tick_q;

    logic             wrap;
    logic [CNT_W-1:0] n_eff;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] high_cnt;
    logic [CNT_W-1:0] div_clamped;

    // A pending divisor is swapped in on the wrap edge, so the
    // counter and high time for that edge already use the new N.
    always_comb begin
        wrap        = (cnt == n_act - ONE);
        n_eff       = (wrap && pend) ? p_div : n_act;
        cnt_next    = wrap ? '0 : cnt + ONE;
`ifdef CLKDIV_HALF_CYCLE_EN
        high_cnt    = n_eff >> 1;
`else
        high_cnt    = (n_eff >> 1) + {{(CNT_W-1){1'b0}}, n_eff[0]};
`endif
        div_clamped = (div_val < TWO) ? TWO : div_val;
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            cnt    <= DEF - ONE;
            n_act  <= DEF;
            p_div  <= DEF;
            pend   <= 1'b0;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            if (en) begin
                cnt    <= cnt_next;
                n_act  <= n_eff;
                clk_q  <= (cnt_next < high_cnt);
                tick_q <= (cnt_next == '0);
            end else begin
                tick_q <= 1'b0;
            end
            // A load on a wrap edge re-arms the flag after the old P is used.
            if (div_load) begin
                p_div <= div_clamped;
                pend  <= 1'b1;
            end else if (en && wrap && pend) begin
                pend  <= 1'b0;
            end
        end
    end

`ifdef CLKDIV_HALF_CYCLE_EN
    logic clk_neg;

    // Half-cycle extension only for odd N; even N keeps its exact duty.
    always_ff @(negedge clk_in) begin
        if (rst) begin
            clk_neg <= 1'b0;
        end else begin
            clk_neg <= clk_q & n_act[0];
        end
    end

    assign clk_out = clk_q | clk_neg;
`else
    assign clk_out = clk_q;
`endif

    assign tick        = tick_q;
    assign upd_pending = pend;

endmodule
